// File: rtl/dflop_pkg.sv
// Shared constants and helpers for the enable/clear register pipeline.
package dflop_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 3;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage : dflop_pkg

// File: rtl/dflop_pipe_stage.sv
// One pipeline stage: a valid bit plus a data word, with load, synchronous
// clear and asynchronous reset. Data only moves when the incoming valid is set,
// so a bubble advances the valid bit alone.
module dflop_pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_n,
  input  logic             load,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  // Next-state: clear beats load; a non-loading stage holds.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    valid_d = valid_q;
    data_d  = data_q;
    if (!clear_n) begin
      valid_d = 1'b0;
      data_d  = RESET_VAL;
    end else if (load) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering. The data word is
    // reset too, because out_data must read RESET_VAL straight after reset.
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule : dflop_pipe_stage

// File: rtl/dflop_pipe_en_clr.sv
// Elastic WIDTH x DEPTH register pipeline with global enable (freeze),
// synchronous active-low flush, valid/ready backpressure with bubble
// collapsing, and an occupancy count. The ready chain is purely combinational
// from out_ready to in_ready; there is deliberately no skid buffer.
module dflop_pipe_en_clr
  import dflop_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              OCC_W     = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0] stage_valid;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_ready;

  // Ready chain: a stage may load if it is empty or the stage after it moves.
  // A running accumulator keeps the chain inside one process.
  always_comb begin
    logic acc;
    stage_ready = '0;
    acc         = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc            = ~stage_valid[i] | acc;
      stage_ready[i] = acc;
    end
  end

  // Stage array; stage 0 takes the upstream word, stage DEPTH-1 drives out.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;

    if (i == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
    end else begin : g_body
      assign up_valid = stage_valid[i-1];
      assign up_data  = stage_data[i-1];
    end

    dflop_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .clear_n (clear_n),
      .load    (enable & stage_ready[i]),
      .valid_i (up_valid),
      .data_i  (up_data),
      .valid_o (stage_valid[i]),
      .data_o  (stage_data[i])
    );
  end

  // Occupancy is the population count of the stage valid bits.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(stage_valid[i]);
    end
  end

  // Handshake outputs are masked while frozen or flushing so neither side
  // ever counts a transfer the pipeline did not perform.
  assign in_ready  = stage_ready[0] & enable & clear_n;
  assign out_valid = stage_valid[DEPTH-1] & enable & clear_n;
  assign out_data  = stage_data[DEPTH-1];

endmodule : dflop_pipe_en_clr

// File: tb/tb_dflop_pipe_en_clr.sv
// Self-checking bench: a cycle-by-cycle vector table for the directed
// scenarios, a FIFO scoreboard for data ordering, a randomised soak and an
// asynchronous reset in mid-stream.
module tb_dflop_pipe_en_clr;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 3;
  localparam logic [7:0] RV    = 8'hE7;

  typedef struct {
    logic       clr_n;
    logic       en;
    logic       iv;
    logic [7:0] idata;
    logic       ordy;
    logic       exp_ir;
    logic       exp_ov;
    logic [7:0] exp_od;
    logic [1:0] exp_occ;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear_n;
  logic       enable;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] occupancy;

  int         tests  = 0;
  int         errors = 0;
  logic [7:0] sb_q [$];
  vec_t       vecs [$];

  always #5 clk = ~clk;

  dflop_pipe_en_clr #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (RV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear_n   (clear_n),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic c, input logic e, input logic iv, input logic [7:0] id,
                              input logic o, input logic ir, input logic ov,
                              input logic [7:0] od, input logic [1:0] occ);
    vec_t v;
    v.clr_n = c;  v.en = e;  v.iv = iv; v.idata = id; v.ordy = o;
    v.exp_ir = ir; v.exp_ov = ov; v.exp_od = od; v.exp_occ = occ;
    vecs.push_back(v);
  endfunction

  // Observe the handshakes of the current cycle (called #1 after inputs settle).
  task automatic scoreboard(input string tag);
    if (in_valid && in_ready) sb_q.push_back(in_data);
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check({tag, " unexpected output"}, 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        check({tag, " scoreboard data"}, 32'(out_data), 32'(sb_q.pop_front()));
      end
    end
    if (!clear_n) sb_q.delete();
  endtask

  task automatic drive(input logic c, input logic e, input logic iv, input logic [7:0] id,
                       input logic o);
    @(negedge clk);
    clear_n = c; enable = e; in_valid = iv; in_data = id; out_ready = o;
    #1;
  endtask

  initial begin
    // Directed scenarios; each one starts from the state the previous left.
    // Stream, latency DEPTH, out_ready held high.
    add(1,1,1,8'h11,1, 1,0,RV,0);
    add(1,1,1,8'h22,1, 1,0,RV,1);
    add(1,1,1,8'h33,1, 1,0,RV,2);
    add(1,1,0,8'h00,1, 1,1,8'h11,3);
    add(1,1,0,8'h00,1, 1,1,8'h22,2);
    add(1,1,0,8'h00,1, 1,1,8'h33,1);
    add(1,1,0,8'h00,1, 1,0,8'h33,0);
    // Backpressure: full pipe stalls input, then drains in order.
    add(1,1,1,8'hA1,0, 1,0,8'h33,0);
    add(1,1,1,8'hA2,0, 1,0,8'h33,1);
    add(1,1,1,8'hA3,0, 1,0,8'h33,2);
    add(1,1,1,8'hA4,0, 0,1,8'hA1,3);
    add(1,1,1,8'hA4,0, 0,1,8'hA1,3);
    add(1,1,1,8'hA4,1, 1,1,8'hA1,3);
    add(1,1,0,8'h00,1, 1,1,8'hA2,3);
    add(1,1,0,8'h00,1, 1,1,8'hA3,2);
    add(1,1,0,8'h00,1, 1,1,8'hA4,1);
    add(1,1,0,8'h00,1, 1,0,8'hA4,0);
    // Bubble collapse under a downstream stall.
    add(1,1,1,8'h55,0, 1,0,8'hA4,0);
    add(1,1,0,8'h00,0, 1,0,8'hA4,1);
    add(1,1,0,8'h00,0, 1,0,8'hA4,1);
    add(1,1,1,8'h66,0, 1,1,8'h55,1);
    add(1,1,0,8'h00,0, 1,1,8'h55,2);
    add(1,1,0,8'h00,0, 1,1,8'h55,2);
    add(1,1,0,8'h00,0, 1,1,8'h55,2);
    add(1,1,0,8'h00,1, 1,1,8'h55,2);
    add(1,1,0,8'h00,1, 1,1,8'h66,1);
    add(1,1,0,8'h00,1, 1,0,8'h66,0);
    // Enable freeze for four cycles mid-stream.
    add(1,1,1,8'h71,1, 1,0,8'h66,0);
    add(1,1,1,8'h72,1, 1,0,8'h66,1);
    for (int k = 0; k < 4; k++) add(1,0,1,8'h73,1, 0,0,8'h66,2);
    add(1,1,1,8'h73,1, 1,0,8'h66,2);
    add(1,1,0,8'h00,1, 1,1,8'h71,3);
    add(1,1,0,8'h00,1, 1,1,8'h72,2);
    add(1,1,0,8'h00,1, 1,1,8'h73,1);
    add(1,1,0,8'h00,1, 1,0,8'h73,0);
    // Clear with two words in flight and a word offered.
    add(1,1,1,8'h81,0, 1,0,8'h73,0);
    add(1,1,1,8'h82,0, 1,0,8'h73,1);
    add(0,1,1,8'h83,0, 0,0,8'h73,2);
    add(1,1,0,8'h00,0, 1,0,RV,0);
    add(1,1,1,8'h84,1, 1,0,RV,0);
    add(1,1,0,8'h00,1, 1,0,RV,1);
    add(1,1,0,8'h00,1, 1,0,RV,1);
    add(1,1,0,8'h00,1, 1,1,8'h84,1);
    add(1,1,0,8'h00,1, 1,0,8'h84,0);

    // Reset with a word offered.
    reset = 1'b1; clear_n = 1'b1; enable = 1'b1;
    in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b0;
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data",  32'(out_data),  32'(RV));
    check("reset occupancy", 32'(occupancy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check("post-reset in_ready", 32'(in_ready), 32'd1);

    // Table-driven directed vectors.
    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].clr_n, vecs[k].en, vecs[k].iv, vecs[k].idata, vecs[k].ordy);
      check($sformatf("vec%0d in_ready",  k), 32'(in_ready),  32'(vecs[k].exp_ir));
      check($sformatf("vec%0d out_valid", k), 32'(out_valid), 32'(vecs[k].exp_ov));
      check($sformatf("vec%0d out_data",  k), 32'(out_data),  32'(vecs[k].exp_od));
      check($sformatf("vec%0d occupancy", k), 32'(occupancy), 32'(vecs[k].exp_occ));
      scoreboard($sformatf("vec%0d", k));
    end

    // Random soak: occupancy must equal words accepted but not yet delivered.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 40) != 0), ($urandom_range(0, 5) != 0),
            1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0));
      check($sformatf("rnd%0d occupancy", k), 32'(occupancy), 32'(sb_q.size()));
      if (!enable || !clear_n) begin
        check($sformatf("rnd%0d masked in_ready", k),  32'(in_ready),  32'd0);
        check($sformatf("rnd%0d masked out_valid", k), 32'(out_valid), 32'd0);
      end else if (out_ready) begin
        check($sformatf("rnd%0d in_ready open", k), 32'(in_ready), 32'd1);
      end else if (occupancy == 2'(DEPTH)) begin
        check($sformatf("rnd%0d in_ready full", k), 32'(in_ready), 32'd0);
      end
      scoreboard($sformatf("rnd%0d", k));
    end
    for (int k = 0; k < DEPTH + 1; k++) begin
      drive(1, 1, 0, 8'h00, 1);
      scoreboard($sformatf("drain%0d", k));
    end
    check("drain scoreboard empty", 32'(sb_q.size()), 32'd0);
    check("drain occupancy", 32'(occupancy), 32'd0);

    // Asynchronous reset in mid-stream.
    drive(1, 1, 1, 8'hC1, 0); scoreboard("mid c1");
    drive(1, 1, 1, 8'hC2, 0); scoreboard("mid c2");
    drive(1, 1, 1, 8'hC3, 0);
    check("mid occupancy before reset", 32'(occupancy), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset out_data",  32'(out_data),  32'(RV));
    check("mid reset occupancy", 32'(occupancy), 32'd0);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check("mid post-reset in_ready", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule : tb_dflop_pipe_en_clr
